// File: rtl/cpu_pkg.sv
// Shared CPU types: operation encoding, multicycle unit request/response and HI/LO controller state.
package cpu_pkg;

  typedef logic [31:0] uint32_t;
  typedef logic [63:0] uint64_t;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
    OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO
  } op_t;

  typedef struct packed {
    logic    is_multicyc;
    op_t     op;
    uint32_t reg0;
    uint32_t reg1;
    uint64_t hilo;
  } multicyc_req_t;

  typedef struct packed {
    logic    ready;
    logic    valid;
    uint64_t hilo;
  } multicyc_resp_t;

  typedef enum logic [1:0] {MC_IDLE, MC_BUSY, MC_DONE, MC_DRAIN} mc_state_t;

  function automatic logic is_multicyc_op(input op_t op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
           (op == OP_DIVU) || (op == OP_MTHI) || (op == OP_MTLO);
  endfunction

  function automatic logic is_mf_op(input op_t op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/multicyc_ctrl.sv
// EX-stage controller for the multicycle unit: issues ops, stalls EX until the result lands, owns HI/LO.
// Issue and stall are combinational; hilo commits on the edge that sees a valid response.
module multicyc_ctrl
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  op_t            ex_op,
  input  uint32_t        ex_reg0,
  input  uint32_t        ex_reg1,
  input  logic           ex_hold,
  input  logic           flush,
  output multicyc_req_t  multicyc_req,
  input  multicyc_resp_t multicyc_resp,
  output logic           ex_stall,
  output uint64_t        hilo,
  output uint32_t        mf_data
);

  mc_state_t state_q, state_d;
  uint64_t   hilo_q, hilo_d;

  logic    op_mc, op_mf, issue, commit, stall_raw;
  uint64_t mf_src;

  assign op_mc = is_multicyc_op(ex_op);
  assign op_mf = is_mf_op(ex_op);
  assign issue = ex_valid & op_mc & ~flush & multicyc_resp.ready;

  always_comb begin
    state_d   = state_q;
    hilo_d    = hilo_q;
    commit    = 1'b0;
    stall_raw = 1'b0;
    unique case (state_q)
      MC_IDLE: begin
        stall_raw = issue | (ex_valid & op_mc & ~multicyc_resp.ready & ~flush);
        if (issue) state_d = MC_BUSY;
      end
      MC_BUSY: begin
        stall_raw = ~multicyc_resp.valid;
        if (multicyc_resp.valid) begin
          if (!flush) begin
            commit  = 1'b1;
            hilo_d  = multicyc_resp.hilo;
            state_d = ex_hold ? MC_DONE : MC_IDLE;
          end else begin
            state_d = MC_IDLE;
          end
        end else if (flush) begin
          state_d = MC_DRAIN;
        end
      end
      // Result already committed while EX is held: wait for the instruction to leave without re-issuing.
      MC_DONE: begin
        if (!ex_hold || flush) state_d = MC_IDLE;
      end
      MC_DRAIN: begin
        stall_raw = ex_valid & (op_mc | op_mf);
        if (multicyc_resp.valid) state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MC_IDLE;
      hilo_q  <= '0;
    end else begin
      state_q <= state_d;
      hilo_q  <= hilo_d;
    end
  end

  assign mf_src = commit ? multicyc_resp.hilo : hilo_q;

  always_comb begin
    mf_data = '0;
    if (rst) begin
      if (ex_op == OP_MFHI)      mf_data = mf_src[63:32];
      else if (ex_op == OP_MFLO) mf_data = mf_src[31:0];
    end
  end

  assign ex_stall = stall_raw & ~flush & rst;
  assign hilo     = hilo_q;

  assign multicyc_req.is_multicyc = (state_q == MC_IDLE) & issue & rst;
  assign multicyc_req.op          = ex_op;
  assign multicyc_req.reg0        = ex_reg0;
  assign multicyc_req.reg1        = ex_reg1;
  assign multicyc_req.hilo        = hilo_q;

endmodule

// File: tb/tb_multicyc_ctrl.sv
// Directed bench for multicyc_ctrl; the bench plays the multicycle unit with hand-computed results.
module tb_multicyc_ctrl;
  import cpu_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           ex_valid;
  op_t            ex_op;
  uint32_t        ex_reg0, ex_reg1;
  logic           ex_hold, flush;
  multicyc_req_t  multicyc_req;
  multicyc_resp_t multicyc_resp;
  logic           ex_stall;
  uint64_t        hilo;
  uint32_t        mf_data;

  int n_vec  = 0;
  int n_bad  = 0;
  int pulses = 0;

  multicyc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_reg0      (ex_reg0),
    .ex_reg1      (ex_reg1),
    .ex_hold      (ex_hold),
    .flush        (flush),
    .multicyc_req (multicyc_req),
    .multicyc_resp(multicyc_resp),
    .ex_stall     (ex_stall),
    .hilo         (hilo),
    .mf_data      (mf_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue pulses are tallied at the falling edge, where the inputs of the current cycle are stable.
  task automatic step();
    @(negedge clk);
    if (multicyc_req.is_multicyc) pulses++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                = 1'b0;
    ex_valid           = 1'b1;
    ex_op              = OP_MULT;
    ex_reg0            = '0;
    ex_reg1            = '0;
    ex_hold            = 1'b0;
    flush              = 1'b0;
    multicyc_resp      = '0;
    multicyc_resp.ready = 1'b1;
    #2;
    chk("rst_stall", 64'(ex_stall), 64'd0);
    chk("rst_issue", 64'(multicyc_req.is_multicyc), 64'd0);
    chk("rst_hilo", hilo, 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(MC_IDLE));
    ex_op = OP_MFHI;
    #1;
    chk("rst_mf", 64'(mf_data), 64'd0);
    ex_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("idle_stall", 64'(ex_stall), 64'd0);

    // MTHI from reset
    ex_valid = 1'b1; ex_op = OP_MTHI; ex_reg0 = 32'h1234_5678;
    #1;
    chk("mthi_issue", 64'(multicyc_req.is_multicyc), 64'd1);
    chk("mthi_stall", 64'(ex_stall), 64'd1);
    chk("mthi_reg0", 64'(multicyc_req.reg0), 64'h1234_5678);
    step();
    chk("mthi_busy", 64'(dut.state_q), 64'(MC_BUSY));
    chk("mthi_noreissue", 64'(multicyc_req.is_multicyc), 64'd0);
    chk("mthi_stall_b1", 64'(ex_stall), 64'd1);
    step();
    chk("mthi_stall_b2", 64'(ex_stall), 64'd1);
    multicyc_resp.valid = 1'b1; multicyc_resp.hilo = 64'h1234_5678_0000_0000;
    #1;
    chk("mthi_commit_stall", 64'(ex_stall), 64'd0);
    step();
    multicyc_resp.valid = 1'b0; ex_valid = 1'b0;
    #1;
    chk("mthi_hilo", hilo, 64'h1234_5678_0000_0000);
    chk("mthi_idle", 64'(dut.state_q), 64'(MC_IDLE));

    // MULT then MFLO/MFHI
    ex_valid = 1'b1; ex_op = OP_MULT; ex_reg0 = 32'hFFFF_FFFF; ex_reg1 = 32'h2;
    #1;
    chk("mult_issue", 64'(multicyc_req.is_multicyc), 64'd1);
    step();
    multicyc_resp.valid = 1'b1; multicyc_resp.hilo = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    chk("mult_commit_stall", 64'(ex_stall), 64'd0);
    step();
    multicyc_resp.valid = 1'b0; ex_op = OP_MFLO;
    #1;
    chk("mflo_data", 64'(mf_data), 64'hFFFF_FFFE);
    chk("mflo_stall", 64'(ex_stall), 64'd0);
    chk("mflo_noissue", 64'(multicyc_req.is_multicyc), 64'd0);
    chk("req_hilo", multicyc_req.hilo, 64'hFFFF_FFFF_FFFF_FFFE);
    ex_op = OP_MFHI;
    #1;
    chk("mfhi_data", 64'(mf_data), 64'hFFFF_FFFF);
    ex_op = OP_ADD;
    #1;
    chk("add_mf_zero", 64'(mf_data), 64'd0);
    step();

    // DIV -7 / 2: quotient -3 in LO, remainder -1 in HI
    ex_op = OP_DIV; ex_reg0 = 32'hFFFF_FFF9; ex_reg1 = 32'h2;
    #1;
    chk("div_issue_stall", 64'(ex_stall), 64'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("div_busy_stall", 64'(ex_stall), 64'd1);
      step();
    end
    multicyc_resp.valid = 1'b1; multicyc_resp.hilo = 64'hFFFF_FFFF_FFFF_FFFD;
    ex_op = OP_MFLO;
    #1;
    chk("div_commit_stall", 64'(ex_stall), 64'd0);
    chk("div_bypass", 64'(mf_data), 64'hFFFF_FFFD);
    step();
    multicyc_resp.valid = 1'b0; ex_valid = 1'b0;
    #1;
    chk("div_hilo", hilo, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIVU flushed three cycles after issue, MULTU waits out the drain
    ex_valid = 1'b1; ex_op = OP_DIVU; ex_reg0 = 32'd100; ex_reg1 = 32'd7;
    step();
    step();
    step();
    flush = 1'b1;
    #1;
    chk("flush_stall", 64'(ex_stall), 64'd0);
    step();
    flush = 1'b0; ex_op = OP_MULTU; ex_reg0 = 32'd3; ex_reg1 = 32'd5;
    #1;
    chk("drain_state", 64'(dut.state_q), 64'(MC_DRAIN));
    chk("drain_stall", 64'(ex_stall), 64'd1);
    chk("drain_noissue", 64'(multicyc_req.is_multicyc), 64'd0);
    step();
    chk("drain_stall2", 64'(ex_stall), 64'd1);
    multicyc_resp.valid = 1'b1; multicyc_resp.hilo = 64'hDEAD_BEEF_CAFE_F00D;
    #1;
    chk("drain_valid_stall", 64'(ex_stall), 64'd1);
    step();
    multicyc_resp.valid = 1'b0;
    #1;
    chk("drain_idle", 64'(dut.state_q), 64'(MC_IDLE));
    chk("drain_hilo", hilo, 64'hFFFF_FFFF_FFFF_FFFD);
    chk("multu_issue", 64'(multicyc_req.is_multicyc), 64'd1);
    chk("multu_issue_stall", 64'(ex_stall), 64'd1);

    // MULTU 3x5 held across commit
    pulses = 0;
    step();
    ex_hold = 1'b1;
    #1;
    chk("multu_busy_stall", 64'(ex_stall), 64'd1);
    step();
    multicyc_resp.valid = 1'b1; multicyc_resp.hilo = 64'd15;
    #1;
    chk("multu_commit_stall", 64'(ex_stall), 64'd0);
    step();
    multicyc_resp.valid = 1'b0;
    #1;
    chk("done_state", 64'(dut.state_q), 64'(MC_DONE));
    chk("done_hilo", hilo, 64'd15);
    chk("done_noissue", 64'(multicyc_req.is_multicyc), 64'd0);
    chk("done_stall", 64'(ex_stall), 64'd0);
    step();
    chk("done_state2", 64'(dut.state_q), 64'(MC_DONE));
    ex_hold = 1'b0; ex_valid = 1'b0;
    step();
    chk("done_exit", 64'(dut.state_q), 64'(MC_IDLE));
    chk("multu_pulses", 64'(pulses), 64'd1);

    // unit not ready: stall without issue
    ex_valid = 1'b1; ex_op = OP_MTLO; multicyc_resp.ready = 1'b0;
    #1;
    chk("notrdy_stall", 64'(ex_stall), 64'd1);
    chk("notrdy_noissue", 64'(multicyc_req.is_multicyc), 64'd0);
    step();
    chk("notrdy_idle", 64'(dut.state_q), 64'(MC_IDLE));
    multicyc_resp.ready = 1'b1;

    // flush on a MULT in IDLE, then reset mid-BUSY
    ex_op = OP_MULT; ex_reg0 = 32'd5; ex_reg1 = 32'd6; flush = 1'b1;
    #1;
    chk("flush_noissue", 64'(multicyc_req.is_multicyc), 64'd0);
    chk("flush_idle_stall", 64'(ex_stall), 64'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_idle_state", 64'(dut.state_q), 64'(MC_IDLE));
    chk("flush_hilo", hilo, 64'd15);
    step();
    chk("rst_mid_busy", 64'(dut.state_q), 64'(MC_BUSY));
    rst = 1'b0;
    #1;
    chk("arst_state", 64'(dut.state_q), 64'(MC_IDLE));
    chk("arst_hilo", hilo, 64'd0);
    chk("arst_stall", 64'(ex_stall), 64'd0);
    chk("arst_issue", 64'(multicyc_req.is_multicyc), 64'd0);
    ex_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
